// File: rtl/rsa256_pkg.sv
// ---------------------------------------------------------------------------
// rsa256_pkg
// Shared types and constants for the RSA256 wrapper:
//   - state_e  : controller states (QUERY_RX, READ, CALC, QUERY_TX, WRITE)
//   - phase_e  : what the incoming 32-byte block is loaded into (N, d, a)
//   - UART register map and status bit positions
//   - block sizes in bytes (32 in, 31 out)
//   - tx_word  : helper that places a byte into the UART txdata word
// ---------------------------------------------------------------------------
package rsa256_pkg;

    localparam logic [4:0] RX_ADDR     = 5'd0;
    localparam logic [4:0] TX_ADDR     = 5'd4;
    localparam logic [4:0] STATUS_ADDR = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;

    localparam int BYTES_IN  = 32;
    localparam int BYTES_OUT = 31;

    // Byte counter values at which the last byte of a block completes
    localparam logic [4:0] LAST_IN_IDX  = 5'(BYTES_IN - 1);
    localparam logic [4:0] LAST_OUT_IDX = 5'(BYTES_OUT - 1);

    typedef enum logic [2:0] {
        QUERY_RX = 3'd0,
        READ     = 3'd1,
        CALC     = 3'd2,
        QUERY_TX = 3'd3,
        WRITE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        LOAD_N = 2'd0,
        LOAD_D = 2'd1,
        LOAD_A = 2'd2
    } phase_e;

    // UART data registers carry the byte in the low 8 bits
    function automatic logic [31:0] tx_word(input logic [7:0] data_byte);
        return {24'd0, data_byte};
    endfunction

endpackage

// File: rtl/rsa256_wrapper_if.sv
// ---------------------------------------------------------------------------
// rsa256_avm_if
// Avalon-MM bus between the RSA256 wrapper (master) and the UART (slave).
//   avm_address     : word-aligned register address (5 bits)
//   avm_read        : read request
//   avm_readdata    : read data, byte in [7:0]
//   avm_write       : write request
//   avm_writedata   : write data, byte in [7:0]
//   avm_waitrequest : slave stall
// ---------------------------------------------------------------------------
interface rsa256_avm_if;

    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/rsa256_byte_shifter.sv
// ---------------------------------------------------------------------------
// rsa256_byte_shifter
// 256-bit register that is either loaded in parallel or shifted left by one
// byte with a new byte entering at the bottom. Used for N, d, a (byte-wise
// fill, MSB first) and for the result (parallel load, then drained from the
// top one byte at a time).
// Parameters:
//   OUT_MSB    : MSB of the byte presented on o_top_byte
// Ports:
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_load     : parallel load of i_load_data
//   i_load_data: value to load
//   i_shift    : shift left by 8, i_byte enters at [7:0]
//   i_byte     : byte shifted in
//   o_data     : register contents
//   o_top_byte : o_data[OUT_MSB -: 8]
// ---------------------------------------------------------------------------
module rsa256_byte_shifter #(
    parameter int OUT_MSB = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [255:0] i_load_data,
    input  logic         i_shift,
    input  logic [7:0]   i_byte,
    output logic [255:0] o_data,
    output logic [7:0]   o_top_byte
);

    logic [255:0] data_r;

    // Load has priority over shift; the controller never requests both
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r <= 256'd0;
        end else if (i_load) begin
            data_r <= i_load_data;
        end else if (i_shift) begin
            data_r <= {data_r[247:0], i_byte};
        end
    end

    assign o_data     = data_r;
    assign o_top_byte = data_r[OUT_MSB -: 8];

endmodule

// File: rtl/rsa256_wrapper.sv
// ---------------------------------------------------------------------------
// rsa256_wrapper
// Avalon-MM master that feeds the RSA256 core from the RS232 UART.
// Loads N and d once (32 bytes each, MSB first), then for every 32-byte
// cipher block pulses o_core_start, waits for i_core_finished and sends the
// 31 low-order result bytes (bits 247:0, MSB first) back over the UART.
// Ports:
//   avm_clk          : clock
//   avm_rst_n        : asynchronous active-low reset
//   avm              : Avalon-MM master port (rsa256_avm_if.master)
//   o_core_start     : one-cycle start pulse to the core
//   o_core_a/d/n     : cipher text, private key, modulus
//   i_core_result    : core result
//   i_core_finished  : core done pulse
//   i_reload         : (RSA_WRAPPER_RELOAD_EN only) request a new N/d load
// Build option:
//   RSA_WRAPPER_RELOAD_EN : adds i_reload; the next block boundary after a
//   request re-enters the N/d load sequence.
// ---------------------------------------------------------------------------
module rsa256_wrapper
    import rsa256_pkg::*;
(
    input  logic                avm_clk,
    input  logic                avm_rst_n,
    rsa256_avm_if.master        avm,
    output logic                o_core_start,
    output logic [255:0]        o_core_a,
    output logic [255:0]        o_core_d,
    output logic [255:0]        o_core_n,
    input  logic [255:0]        i_core_result,
    input  logic                i_core_finished
`ifdef RSA_WRAPPER_RELOAD_EN
    ,
    input  logic                i_reload
`endif
);

    state_e      state_r;
    phase_e      phase_r;
    logic [4:0]  cnt_r;
    logic [4:0]  addr_r;
    logic        read_r;
    logic        write_r;
    logic [31:0] wdata_r;
    logic        start_r;

    logic        xfer_done_s;
    logic        rx_done_s;
    logic        tx_done_s;
    logic        res_load_s;
    logic        shift_n_s;
    logic        shift_d_s;
    logic        shift_a_s;
    logic        reload_fire_s;
    logic [7:0]  rx_byte_s;
    logic [7:0]  res_top_s;
    logic [255:0] res_data_s;
    logic [7:0]  n_top_s;
    logic [7:0]  d_top_s;
    logic [7:0]  a_top_s;
    logic        unused_bits_s;

    assign xfer_done_s = (read_r | write_r) & ~avm.avm_waitrequest;
    assign rx_done_s   = (state_r == READ) & xfer_done_s;
    assign tx_done_s   = (state_r == WRITE) & xfer_done_s;
    assign res_load_s  = (state_r == CALC) & i_core_finished;
    assign rx_byte_s   = avm.avm_readdata[7:0];

`ifdef RSA_WRAPPER_RELOAD_EN
    logic reload_pend_r;

    // Reload only acts on a block boundary: idle in QUERY_RX with no bytes taken
    assign reload_fire_s = reload_pend_r & (state_r == QUERY_RX) & (cnt_r == 5'd0);

    // Sticky reload request, consumed when the phase is rewound
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            reload_pend_r <= 1'b0;
        end else if (reload_fire_s) begin
            reload_pend_r <= 1'b0;
        end else if (i_reload) begin
            reload_pend_r <= 1'b1;
        end
    end
`else
    assign reload_fire_s = 1'b0;
`endif

    // Steer each received byte into the register selected by the load phase
    always_comb begin
        shift_n_s = 1'b0;
        shift_d_s = 1'b0;
        shift_a_s = 1'b0;
        if (rx_done_s) begin
            case (phase_r)
                LOAD_N:  shift_n_s = 1'b1;
                LOAD_D:  shift_d_s = 1'b1;
                LOAD_A:  shift_a_s = 1'b1;
                default: shift_n_s = 1'b0;
            endcase
        end else begin
            shift_n_s = 1'b0;
        end
    end

    // Controller: each state raises its request one cycle after entry and
    // drops it on the completing edge, so a byte costs status read + data read
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_r <= QUERY_RX;
            phase_r <= LOAD_N;
            cnt_r   <= 5'd0;
            addr_r  <= STATUS_ADDR;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            wdata_r <= 32'd0;
            start_r <= 1'b0;
        end else begin
            start_r <= 1'b0;
            case (state_r)
                QUERY_RX: begin
                    if (reload_fire_s) begin
                        phase_r <= LOAD_N;
                    end
                    if (!read_r) begin
                        read_r <= 1'b1;
                    end else if (xfer_done_s) begin
                        read_r <= 1'b0;
                        if (avm.avm_readdata[RX_OK_BIT]) begin
                            addr_r  <= RX_ADDR;
                            state_r <= READ;
                        end
                    end
                end
                READ: begin
                    if (!read_r) begin
                        read_r <= 1'b1;
                    end else if (xfer_done_s) begin
                        read_r <= 1'b0;
                        addr_r <= STATUS_ADDR;
                        cnt_r  <= cnt_r + 5'd1;
                        state_r <= QUERY_RX;
                        if (cnt_r == LAST_IN_IDX) begin
                            case (phase_r)
                                LOAD_N: phase_r <= LOAD_D;
                                LOAD_D: phase_r <= LOAD_A;
                                default: begin
                                    start_r <= 1'b1;
                                    state_r <= CALC;
                                end
                            endcase
                        end
                    end
                end
                CALC: begin
                    if (i_core_finished) begin
                        cnt_r   <= 5'd0;
                        state_r <= QUERY_TX;
                    end
                end
                QUERY_TX: begin
                    if (!read_r) begin
                        read_r <= 1'b1;
                    end else if (xfer_done_s) begin
                        read_r <= 1'b0;
                        if (avm.avm_readdata[TX_OK_BIT]) begin
                            addr_r  <= TX_ADDR;
                            wdata_r <= tx_word(res_top_s);
                            state_r <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (!write_r) begin
                        write_r <= 1'b1;
                    end else if (xfer_done_s) begin
                        write_r <= 1'b0;
                        addr_r  <= STATUS_ADDR;
                        if (cnt_r == LAST_OUT_IDX) begin
                            cnt_r   <= 5'd0;
                            state_r <= QUERY_RX;
                        end else begin
                            cnt_r   <= cnt_r + 5'd1;
                            state_r <= QUERY_TX;
                        end
                    end
                end
                default: begin
                    state_r <= QUERY_RX;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    addr_r  <= STATUS_ADDR;
                end
            endcase
        end
    end

    rsa256_byte_shifter #(.OUT_MSB(255)) u_n (
        .i_clk       (avm_clk),
        .i_rst_n     (avm_rst_n),
        .i_load      (1'b0),
        .i_load_data (256'd0),
        .i_shift     (shift_n_s),
        .i_byte      (rx_byte_s),
        .o_data      (o_core_n),
        .o_top_byte  (n_top_s)
    );

    rsa256_byte_shifter #(.OUT_MSB(255)) u_d (
        .i_clk       (avm_clk),
        .i_rst_n     (avm_rst_n),
        .i_load      (1'b0),
        .i_load_data (256'd0),
        .i_shift     (shift_d_s),
        .i_byte      (rx_byte_s),
        .o_data      (o_core_d),
        .o_top_byte  (d_top_s)
    );

    rsa256_byte_shifter #(.OUT_MSB(255)) u_a (
        .i_clk       (avm_clk),
        .i_rst_n     (avm_rst_n),
        .i_load      (1'b0),
        .i_load_data (256'd0),
        .i_shift     (shift_a_s),
        .i_byte      (rx_byte_s),
        .o_data      (o_core_a),
        .o_top_byte  (a_top_s)
    );

    // Plaintext occupies bits 247:0, so the byte to send sits at 247:240
    rsa256_byte_shifter #(.OUT_MSB(247)) u_res (
        .i_clk       (avm_clk),
        .i_rst_n     (avm_rst_n),
        .i_load      (res_load_s),
        .i_load_data (i_core_result),
        .i_shift     (tx_done_s),
        .i_byte      (8'h00),
        .o_data      (res_data_s),
        .o_top_byte  (res_top_s)
    );

    // Bits with no consumer in this block
    assign unused_bits_s = ^{n_top_s, d_top_s, a_top_s, res_data_s, avm.avm_readdata[31:8]};

    assign avm.avm_address   = addr_r;
    assign avm.avm_read      = read_r;
    assign avm.avm_write     = write_r;
    assign avm.avm_writedata = wdata_r;
    assign o_core_start      = start_r;

endmodule

// File: doc/rsa256_wrapper.md
Name: rsa256_wrapper

Overview:
- Initiator-side controller for the RSA256 decryption core.
- Acts as an Avalon-MM master to the RS232 UART.
- Loads modulus N and private key d once, then repeatedly:
  - receives a 256-bit cipher block,
  - drives the core's start/operand interface and waits for its finished pulse,
  - transmits the 248-bit plaintext back over the UART.
- Sits between the UART IP and the core in the lab2 top level.

Parameters:
RX_ADDR, 5'd0, UART rxdata register address (word 0)
TX_ADDR, 5'd4, UART txdata register address (word 1)
STATUS_ADDR, 5'd8, UART status register address (word 2)
RX_OK_BIT, 7, status bit: rx byte ready
TX_OK_BIT, 6, status bit: tx ready

Ports:
avm_clk  in  1  clock
avm_rst_n  in  1  asynchronous active-low reset
avm_address  out  5  Avalon address
avm_read  out  1  Avalon read request
avm_readdata  in  32  Avalon read data, byte in [7:0]
avm_write  out  1  Avalon write request
avm_writedata  out  32  Avalon write data, byte in [7:0]
avm_waitrequest  in  1  Avalon stall
o_core_start  out  1  one-cycle start pulse to core
o_core_a  out  256  cipher text
o_core_d  out  256  private key
o_core_n  out  256  modulus
i_core_result  in  256  core result
i_core_finished  in  1  core done pulse

Behaviour:
- Clock and reset:
  - One clock, avm_clk.
  - Reset is asynchronous and active-low on avm_rst_n.
  - Reset values: all outputs 0; avm_address=STATUS_ADDR; state=QUERY_RX; phase=LOAD_N; byte counter=0; n/d/a/result registers=0.
- Avalon master rules:
  - Address, read, write and writedata are held stable while avm_waitrequest=1.
  - A transfer completes on the first edge where read|write=1 and avm_waitrequest=0.
  - avm_readdata is sampled on that edge.
  - read and write are never asserted together.
- States:
  - QUERY_RX: read STATUS_ADDR.
    - On completion with readdata[RX_OK_BIT]=1: address=RX_ADDR, go READ.
    - Otherwise re-poll.
  - READ: read RX_ADDR.
    - On completion, shift the byte into the phase register, MSB first: reg <= {reg[247:0], byte}.
    - Increment counter; address=STATUS_ADDR.
    - After byte 31 (counter wraps 31->0) advance phase: LOAD_N -> LOAD_D -> LOAD_A. Return to QUERY_RX.
    - In LOAD_A, after byte 31: pulse o_core_start for exactly 1 cycle, go CALC.
  - CALC: wait for i_core_finished.
    - On i_core_finished: latch result <= i_core_result, counter=0, go QUERY_TX.
    - o_core_a/d/n stay stable throughout CALC.
  - QUERY_TX: read STATUS_ADDR.
    - On completion with bit TX_OK_BIT=1: address=TX_ADDR, writedata={24'b0, result[247:240]}, go WRITE.
  - WRITE: write TX_ADDR.
    - On completion: result <= result<<8, increment counter.
    - After 31 bytes (counter==30 completing), counter=0, phase stays LOAD_A, go QUERY_RX.
    - Otherwise go QUERY_TX.
- Key persistence: N and d persist across blocks until reset.
- Boundary conditions:
  - i_core_finished outside CALC is ignored.
  - Reset mid-transfer drops read/write immediately; no partial byte is kept.
  - A waitrequest held indefinitely stalls without state change.
- Latency: minimum 4 cycles per received byte with no waitrequest (status read + data read). Start pulse follows the final cipher byte's read completion by 1 cycle.

Optional Feature:
- Macro RSA_WRAPPER_RELOAD_EN.
- With the macro defined:
  - Extra input port i_reload (1 bit), sampled every cycle.
  - A registered sticky flag is set by i_reload and cleared on action.
  - Action: at the next point where state=QUERY_RX and counter=0, phase <= LOAD_N, so new N and d are loaded. Action is not taken in the middle of a cipher block, CALC, or TX.
- Without the macro: no port; phase never returns to LOAD_N except via reset.

Decomposition:
- Package rsa256_pkg:
  - state enum (QUERY_RX, READ, CALC, QUERY_TX, WRITE) and phase enum (LOAD_N, LOAD_D, LOAD_A);
  - address/bit parameters as localparams;
  - BYTES_IN=32, BYTES_OUT=31.
- Sub-module rsa256_byte_shifter: 256-bit load-shift register with byte-in and top-byte-out, used for N, d, a and result.

Test Plan:
- Reset: avm_rst_n=0 mid-WRITE -> avm_write=0, avm_read=0, o_core_start=0 immediately; after release, first read is at STATUS_ADDR.
- Key load: UART supplies N=33 and d=7 (each as 32 bytes, last byte 0x21 / 0x07), then a=4 -> o_core_n=33, o_core_d=7, o_core_a=4, and a single 1-cycle o_core_start. Bench core model returns 16 -> 31 writes, first 30 bytes 0x00, last 0x10.
- Status polling: rx_ok=0 for 5 polls, then 1 -> no RX_ADDR read occurs before rx_ok=1; tx_ok held 0 -> no write issued.
- Waitrequest: waitrequest=1 for 3 cycles on every read -> address/read stable during stall; bytes captured correctly; no duplicates.
- Back-to-back blocks: two cipher blocks 4 and 5 with N=33, d=7 -> outputs 16 then 14; N and d are not re-read.
- Spurious finished: i_core_finished pulsed during QUERY_RX -> no state change, no write.
- Reload (RSA_WRAPPER_RELOAD_EN): i_reload mid-TX -> remaining bytes still sent; the next 32 bytes load N.
